mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-master arbiter that shares one downstream memory/peripheral request port between the CPU bus interface (master 0) and a second bus master (master 1, e.g. DMA or video fetch). Each master uses the single-cycle-pulse request protocol of the CPU bus interface: `req_valid` pulse, level `req_ready`, `dout_valid` write beats, and `din_valid`/`din_ack` read beats. The block latches each master's pulsed request into a one-entry slot. It grants one master at a time, forwards that master's request with valid/ready to the slave, and routes data beats until the burst length is exhausted.

## Interface
Parameters:
- `ADDR_W`, 32, request address width
- `DATA_W`, 32, data beat width
- `LEN_W`, 3, burst length field width (legal lengths 1 and 4)

Ports:
- `clk_i`  in  1  single clock
- `rst_ni`  in  1  reset, asynchronous, active-low
- `mN_req_valid`  in  1  request pulse, one cycle (N = 0, 1)
- `mN_req_ready`  out  1  level; high while master N owns the slave and its request has been accepted
- `mN_req_len`  in  LEN_W  beat count
- `mN_req_mask`  in  4  byte mask
- `mN_req_addr`  in  ADDR_W  address
- `mN_req_we`  in  1  1 = write
- `mN_dout_valid`  in  1  write beat pulse
- `mN_dout`  in  DATA_W  write data
- `mN_din_valid`  out  1  read beat available
- `mN_din`  out  DATA_W  read data
- `mN_din_ack`  in  1  read beat consumed
- `s_req_valid`  out  1  request to slave, held until `s_req_ready`
- `s_req_ready`  in  1  slave accepts request
- `s_req_len`, `s_req_mask`, `s_req_addr`, `s_req_we`  out  LEN_W / 4 / ADDR_W / 1  forwarded request fields
- `s_dout_valid`  out  1  forwarded write beat
- `s_dout`  out  DATA_W  forwarded write data
- `s_din_valid`  in  1  read beat from slave
- `s_din`  in  DATA_W  read data from slave
- `s_din_ack`  out  1  forwarded read acknowledge
- `err_o`  out  1  sticky; set when a request pulse hits a full slot

## Operation
- Each master has a slot: a valid bit plus the captured fields.
  - An `mN_req_valid` pulse with the slot empty captures the fields and sets the valid bit.
  - A pulse with the slot full is dropped and sets `err_o`.
- FSM states:
  - IDLE: if any slot is valid, pick a winner, latch the grant index, load `s_req_*` from the winner's slot, and go to ISSUE.
  - ISSUE: `s_req_valid`=1. When `s_req_ready`=1, clear the winner's slot valid bit, drop `s_req_valid`, load beat counter = len (len 0 is treated as 1), set `mN_req_ready`=1, and go to XFER.
  - XFER: count beats down.
    - A write beat is a granted `dout_valid`.
    - A read beat is a granted `din_ack`.
    - On the last beat, clear `mN_req_ready` and return to IDLE.
- Data routing, combinational, active only in XFER and only for the granted master:
  - `s_dout_valid`/`s_dout` come from the granted master.
  - `mN_din_valid` = `s_din_valid` gated by grant; `mN_din` = `s_din` (both masters).
  - `s_din_ack` comes from the granted master's `din_ack`.
  - Non-granted masters see `din_valid`=0; their `dout_valid` is ignored.
- Both slots valid in IDLE: winner is chosen per Configuration.
- A pulse arriving in the same cycle the slot is cleared (ISSUE→XFER) is captured; the slot ends valid.
- Reset, asynchronous and at any time:
  - State → IDLE, slots empty, counter 0.
  - `err_o`, `s_req_valid`, `mN_req_ready`, `s_dout_valid`, `s_din_ack`, `mN_din_valid` = 0.
  - `s_req_*` fields = 0; last-grant pointer = 1.

## Timing
- A pulse in cycle 0 appears in the slot at cycle 1. IDLE decides in cycle 1, so `s_req_valid` is high from cycle 2.
  - Minimum request latency: 2 cycles.
- `s_req_ready` high in cycle k → `mN_req_ready`=1 from cycle k+1.
- A last beat in cycle j → `mN_req_ready`=0 from cycle j+1, IDLE in cycle j+1, next `s_req_valid` at j+2 at the earliest.
- Data path adds zero latency. Beats are counted on the edge of the cycle in which they are presented.

## Configuration
- `MEM_ARBITER_RR_EN` defined: round-robin. With both slots valid, the master not granted last wins. The last-grant pointer updates on every IDLE→ISSUE transition.
- Not defined: fixed priority, master 0 always wins. The pointer logic is removed.

## Structure
- Shared package `mem_arbiter_pkg`:
  - state enum (IDLE, ISSUE, XFER)
  - master index constants `M_CPU`=0, `M_AUX`=1
  - `LEN_W`, `ADDR_W`, `DATA_W` defaults
  - a request struct type (len, mask, addr, we)
- Sub-module `mem_arbiter_slot`: one-entry capture register with valid/clear/overflow, instantiated once per master.

## Test plan
- M0 pulse: read, addr 0x00001000, len 1, mask 1111. Slave ready immediately, returns 0xDEADBEEF → `s_req_valid` at cycle 2; `m0_req_ready` high; `m0_din`=0xDEADBEEF with `m0_din_valid`; grant released after `m0_din_ack`.
- M1 write burst: len 4, four `m1_dout_valid` beats 0x1..0x4 → `s_dout` carries 0x1..0x4 in order; `m1_req_ready` drops the cycle after the fourth beat.
- Both masters pulse in the same cycle:
  - with `MEM_ARBITER_RR_EN` after reset → grant order M0, M1, then M0 again on repeat
  - without the macro → M0 wins every time
- M0 pulses twice before its request issues (slave `s_req_ready` held 0) → `err_o`=1 and stays 1; the first request is still served.
- `rst_ni` asserted mid-XFER, after beat 2 of 4 → all outputs 0 immediately (asynchronously); after release, slots are empty and no `s_req_valid` appears until a new pulse.
- Non-granted master drives `dout_valid` during the other master's XFER → `s_dout_valid` stays 0 for those beats; beat count unaffected.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-master memory arbiter.
package mem_arbiter_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int LEN_W_DEF  = 3;

  localparam logic M_CPU = 1'b0;
  localparam logic M_AUX = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    XFER  = 2'd2
  } state_e;

  typedef struct packed {
    logic [LEN_W_DEF-1:0]  len;
    logic [3:0]            mask;
    logic [ADDR_W_DEF-1:0] addr;
    logic                  we;
  } req_t;

endpackage

// File: rtl/mem_arbiter_slot.sv
// One-entry request capture slot: holds a pulsed request until the arbiter
// clears it; a pulse into a full slot is dropped and flagged as overflow.
module mem_arbiter_slot
  import mem_arbiter_pkg::*;
#(
  parameter type T = req_t
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic capture,
  input  T     fields,
  input  logic clear,
  output logic valid,
  output T     data,
  output logic overflow
);

  logic valid_r;
  T     data_r;

  // A clear in the same cycle frees the slot, so a coincident pulse still lands.
  assign overflow = capture & valid_r & ~clear;
  assign valid    = valid_r;
  assign data     = data_r;

  // Slot valid bit and captured request fields.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_r <= 1'b0;
      data_r  <= '0;
    end else if (capture && (!valid_r || clear)) begin
      valid_r <= 1'b1;
      data_r  <= fields;
    end else if (clear) begin
      valid_r <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter sharing one slave request port with burst data routing.
// Build macro MEM_ARBITER_RR_EN selects round-robin; otherwise master 0 has fixed priority.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              m0_req_valid,
  output logic              m0_req_ready,
  input  logic [LEN_W-1:0]  m0_req_len,
  input  logic [3:0]        m0_req_mask,
  input  logic [ADDR_W-1:0] m0_req_addr,
  input  logic              m0_req_we,
  input  logic              m0_dout_valid,
  input  logic [DATA_W-1:0] m0_dout,
  output logic              m0_din_valid,
  output logic [DATA_W-1:0] m0_din,
  input  logic              m0_din_ack,
  input  logic              m1_req_valid,
  output logic              m1_req_ready,
  input  logic [LEN_W-1:0]  m1_req_len,
  input  logic [3:0]        m1_req_mask,
  input  logic [ADDR_W-1:0] m1_req_addr,
  input  logic              m1_req_we,
  input  logic              m1_dout_valid,
  input  logic [DATA_W-1:0] m1_dout,
  output logic              m1_din_valid,
  output logic [DATA_W-1:0] m1_din,
  input  logic              m1_din_ack,
  output logic              s_req_valid,
  input  logic              s_req_ready,
  output logic [LEN_W-1:0]  s_req_len,
  output logic [3:0]        s_req_mask,
  output logic [ADDR_W-1:0] s_req_addr,
  output logic              s_req_we,
  output logic              s_dout_valid,
  output logic [DATA_W-1:0] s_dout,
  input  logic              s_din_valid,
  input  logic [DATA_W-1:0] s_din,
  output logic              s_din_ack,
  output logic              err_o
);

  typedef struct packed {
    logic [LEN_W-1:0]  len;
    logic [3:0]        mask;
    logic [ADDR_W-1:0] addr;
    logic              we;
  } slot_req_t;

  localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

  state_e           state_r, state_nxt_s;
  logic             grant_r, winner_s;
  logic [LEN_W-1:0] cnt_r;
  logic [1:0]       ready_r;
  logic             err_r;
  slot_req_t        sreq_r, win_req_s;
  slot_req_t        m0_fields_s, m1_fields_s, m0_slot_s, m1_slot_s;
  logic [1:0]       slot_v_s, clear_s, ovf_s;
  logic             any_v_s, accept_s, beat_s, last_beat_s;

  assign m0_fields_s = {m0_req_len, m0_req_mask, m0_req_addr, m0_req_we};
  assign m1_fields_s = {m1_req_len, m1_req_mask, m1_req_addr, m1_req_we};

  mem_arbiter_slot #(.T(slot_req_t)) u_slot0 (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .capture  (m0_req_valid),
    .fields   (m0_fields_s),
    .clear    (clear_s[0]),
    .valid    (slot_v_s[0]),
    .data     (m0_slot_s),
    .overflow (ovf_s[0])
  );

  mem_arbiter_slot #(.T(slot_req_t)) u_slot1 (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .capture  (m1_req_valid),
    .fields   (m1_fields_s),
    .clear    (clear_s[1]),
    .valid    (slot_v_s[1]),
    .data     (m1_slot_s),
    .overflow (ovf_s[1])
  );

  assign any_v_s     = |slot_v_s;
  assign accept_s    = (state_r == ISSUE) && s_req_ready;
  assign clear_s[0]  = accept_s && (grant_r == M_CPU);
  assign clear_s[1]  = accept_s && (grant_r == M_AUX);
  assign beat_s      = (state_r == XFER) &&
                       ((grant_r == M_AUX) ? (m1_dout_valid | m1_din_ack)
                                           : (m0_dout_valid | m0_din_ack));
  assign last_beat_s = beat_s && (cnt_r <= LEN_ONE);

`ifdef MEM_ARBITER_RR_EN
  logic last_r;

  // Last-grant pointer; starts at master 1 so master 0 wins the first tie.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_r <= M_AUX;
    end else if ((state_r == IDLE) && any_v_s) begin
      last_r <= winner_s;
    end
  end
`endif

  // Winner selection among valid slots.
  always_comb begin
    winner_s = M_CPU;
    if (slot_v_s[0] && slot_v_s[1]) begin
`ifdef MEM_ARBITER_RR_EN
      winner_s = ~last_r;
`else
      winner_s = M_CPU;
`endif
    end else if (slot_v_s[1]) begin
      winner_s = M_AUX;
    end else begin
      winner_s = M_CPU;
    end
  end

  assign win_req_s = (winner_s == M_AUX) ? m1_slot_s : m0_slot_s;

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    if (any_v_s) state_nxt_s = ISSUE;
               else         state_nxt_s = IDLE;
      ISSUE:   if (s_req_ready) state_nxt_s = XFER;
               else             state_nxt_s = ISSUE;
      XFER:    if (last_beat_s) state_nxt_s = IDLE;
               else             state_nxt_s = XFER;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Grant, forwarded request fields, beat counter and per-master ready.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      grant_r <= M_CPU;
      sreq_r  <= '0;
      cnt_r   <= LEN_ZERO;
      ready_r <= 2'b00;
    end else begin
      case (state_r)
        IDLE: begin
          if (any_v_s) begin
            grant_r <= winner_s;
            sreq_r  <= win_req_s;
          end
        end
        ISSUE: begin
          if (s_req_ready) begin
            cnt_r   <= (sreq_r.len == LEN_ZERO) ? LEN_ONE : sreq_r.len;
            ready_r <= (grant_r == M_AUX) ? 2'b10 : 2'b01;
          end
        end
        XFER: begin
          if (beat_s) begin
            cnt_r <= cnt_r - LEN_ONE;
            if (last_beat_s) ready_r <= 2'b00;
          end
        end
        default: ready_r <= 2'b00;
      endcase
    end
  end

  // Sticky overflow flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_r <= 1'b0;
    end else if (|ovf_s) begin
      err_r <= 1'b1;
    end
  end

  // FSM outputs and zero-latency data routing for the granted master only.
  always_comb begin
    s_req_valid  = 1'b0;
    s_dout_valid = 1'b0;
    s_dout       = (grant_r == M_AUX) ? m1_dout : m0_dout;
    s_din_ack    = 1'b0;
    m0_din_valid = 1'b0;
    m1_din_valid = 1'b0;
    case (state_r)
      ISSUE: s_req_valid = 1'b1;
      XFER: begin
        if (grant_r == M_AUX) begin
          s_dout_valid = m1_dout_valid;
          s_din_ack    = m1_din_ack;
          m1_din_valid = s_din_valid;
        end else begin
          s_dout_valid = m0_dout_valid;
          s_din_ack    = m0_din_ack;
          m0_din_valid = s_din_valid;
        end
      end
      default: s_req_valid = 1'b0;
    endcase
  end

  assign s_req_len    = sreq_r.len;
  assign s_req_mask   = sreq_r.mask;
  assign s_req_addr   = sreq_r.addr;
  assign s_req_we     = sreq_r.we;
  assign m0_req_ready = ready_r[0];
  assign m1_req_ready = ready_r[1];
  assign m0_din       = s_din;
  assign m1_din       = s_din;
  assign err_o        = err_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed stimulus pushes expected slave
// requests and data beats; a negedge monitor pops and compares them.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_req_valid = 1'b0, m1_req_valid = 1'b0;
  logic        m0_req_ready, m1_req_ready;
  logic [2:0]  m0_req_len = 3'd0, m1_req_len = 3'd0;
  logic [3:0]  m0_req_mask = 4'h0, m1_req_mask = 4'h0;
  logic [31:0] m0_req_addr = 32'h0, m1_req_addr = 32'h0;
  logic        m0_req_we = 1'b0, m1_req_we = 1'b0;
  logic        m0_dout_valid = 1'b0, m1_dout_valid = 1'b0;
  logic [31:0] m0_dout = 32'h0, m1_dout = 32'h0;
  logic        m0_din_valid, m1_din_valid;
  logic [31:0] m0_din, m1_din;
  logic        m0_din_ack = 1'b0, m1_din_ack = 1'b0;
  logic        s_req_valid;
  logic        s_req_ready = 1'b0;
  logic [2:0]  s_req_len;
  logic [3:0]  s_req_mask;
  logic [31:0] s_req_addr;
  logic        s_req_we;
  logic        s_dout_valid;
  logic [31:0] s_dout;
  logic        s_din_valid = 1'b0;
  logic [31:0] s_din = 32'h0;
  logic        s_din_ack;
  logic        err_o;

  int checks = 0;
  int errors = 0;
  logic [39:0] exp_req[$];
  logic [31:0] exp_wr[$];
  logic [31:0] exp_rd[$];

  mem_arbiter dut (
    .clk_i(clk), .rst_ni(rst_n),
    .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req_len(m0_req_len),
    .m0_req_mask(m0_req_mask), .m0_req_addr(m0_req_addr), .m0_req_we(m0_req_we),
    .m0_dout_valid(m0_dout_valid), .m0_dout(m0_dout), .m0_din_valid(m0_din_valid),
    .m0_din(m0_din), .m0_din_ack(m0_din_ack),
    .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req_len(m1_req_len),
    .m1_req_mask(m1_req_mask), .m1_req_addr(m1_req_addr), .m1_req_we(m1_req_we),
    .m1_dout_valid(m1_dout_valid), .m1_dout(m1_dout), .m1_din_valid(m1_din_valid),
    .m1_din(m1_din), .m1_din_ack(m1_din_ack),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_len(s_req_len),
    .s_req_mask(s_req_mask), .s_req_addr(s_req_addr), .s_req_we(s_req_we),
    .s_dout_valid(s_dout_valid), .s_dout(s_dout), .s_din_valid(s_din_valid),
    .s_din(s_din), .s_din_ack(s_din_ack), .err_o(err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: every DUT-presented transfer must match the next expected entry.
  always @(negedge clk) begin
    if (rst_n) begin
      if (s_req_valid && s_req_ready) begin
        if (exp_req.size() == 0) chk("req_unexpected", {s_req_we, s_req_len, s_req_mask, s_req_addr}, 64'h0);
        else chk("slave_req", {s_req_we, s_req_len, s_req_mask, s_req_addr}, exp_req.pop_front());
      end
      if (s_dout_valid) begin
        if (exp_wr.size() == 0) chk("wr_unexpected", s_dout, 64'hFFFF_FFFF_FFFF_FFFF);
        else chk("wr_beat", s_dout, exp_wr.pop_front());
      end
      if ((m0_din_valid && m0_din_ack) || (m1_din_valid && m1_din_ack)) begin
        if (exp_rd.size() == 0) chk("rd_unexpected", s_din, 64'hFFFF_FFFF_FFFF_FFFF);
        else chk("rd_beat", m0_din_valid ? m0_din : m1_din, exp_rd.pop_front());
      end
    end
  end

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rdy(input int m);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!((m == 0) ? m0_req_ready : m1_req_ready) && n < 40);
    chk("wait_rdy", (m == 0) ? m0_req_ready : m1_req_ready, 64'h1);
  endtask

  // Wait for whichever master is granted and issue its single write beat.
  task automatic serve_one();
    int n = 0;
    bit own1;
    do begin
      @(negedge clk);
      n++;
    end while (!(m0_req_ready || m1_req_ready) && n < 40);
    chk("serve_wait", m0_req_ready | m1_req_ready, 64'h1);
    own1 = m1_req_ready;
    next_cyc();
    if (own1) m1_dout_valid = 1'b1;
    else      m0_dout_valid = 1'b1;
    next_cyc();
    m0_dout_valid = 1'b0;
    m1_dout_valid = 1'b0;
  endtask

  initial begin
    bit seen;
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_s_req_valid", s_req_valid, 64'h0);
    chk("rst_ready", {m0_req_ready, m1_req_ready}, 64'h0);
    chk("rst_err", err_o, 64'h0);
    chk("rst_fields", {s_req_we, s_req_len, s_req_mask, s_req_addr}, 64'h0);
    next_cyc();
    rst_n = 1'b1;
    s_req_ready = 1'b1;

    // M0 single read: latency and routing
    next_cyc();
    m0_req_valid = 1'b1; m0_req_addr = 32'h0000_1000; m0_req_len = 3'd1;
    m0_req_we = 1'b0; m0_req_mask = 4'hF;
    exp_req.push_back({1'b0, 3'd1, 4'hF, 32'h0000_1000});
    next_cyc();
    m0_req_valid = 1'b0;
    @(negedge clk); chk("lat_cycle1", s_req_valid, 64'h0);
    next_cyc();
    @(negedge clk); chk("lat_cycle2", s_req_valid, 64'h1);
    chk("m0_ready_c2", m0_req_ready, 64'h0);
    next_cyc();
    s_din_valid = 1'b1; s_din = 32'hDEAD_BEEF; m0_din_ack = 1'b1;
    exp_rd.push_back(32'hDEAD_BEEF);
    @(negedge clk);
    chk("m0_ready_c3", m0_req_ready, 64'h1);
    chk("m0_din_valid", m0_din_valid, 64'h1);
    chk("m1_din_gated", m1_din_valid, 64'h0);
    next_cyc();
    s_din_valid = 1'b0; m0_din_ack = 1'b0;
    @(negedge clk); chk("m0_ready_release", m0_req_ready, 64'h0);

    // M1 write burst of 4 with stray M0 beats
    next_cyc();
    m1_req_valid = 1'b1; m1_req_addr = 32'h0000_2000; m1_req_len = 3'd4;
    m1_req_we = 1'b1; m1_req_mask = 4'h3;
    exp_req.push_back({1'b1, 3'd4, 4'h3, 32'h0000_2000});
    for (int i = 1; i <= 4; i++) exp_wr.push_back(32'(i));
    next_cyc();
    m1_req_valid = 1'b0;
    wait_rdy(1);
    next_cyc(); m1_dout_valid = 1'b1; m1_dout = 32'h1;
    next_cyc(); m1_dout_valid = 1'b0; m0_dout_valid = 1'b1; m0_dout = 32'hBAD0;
    @(negedge clk); chk("stray_dout_gated", s_dout_valid, 64'h0);
    next_cyc(); m1_dout_valid = 1'b1; m1_dout = 32'h2;
    next_cyc(); m1_dout = 32'h3; m0_dout_valid = 1'b0;
    next_cyc(); m1_dout = 32'h4;
    @(negedge clk); chk("m1_ready_beat4", m1_req_ready, 64'h1);
    next_cyc(); m1_dout_valid = 1'b0;
    @(negedge clk); chk("m1_ready_drop", m1_req_ready, 64'h0);

    // Simultaneous pulses: M0 wins in either mode
    next_cyc();
    m0_req_valid = 1'b1; m0_req_addr = 32'h3000; m0_req_len = 3'd1; m0_req_we = 1'b1;
    m0_req_mask = 4'hF; m0_dout = 32'hA0;
    m1_req_valid = 1'b1; m1_req_addr = 32'h4000; m1_req_len = 3'd1; m1_req_we = 1'b1;
    m1_req_mask = 4'hF; m1_dout = 32'hB1;
    exp_req.push_back({1'b1, 3'd1, 4'hF, 32'h3000}); exp_wr.push_back(32'hA0);
    exp_req.push_back({1'b1, 3'd1, 4'hF, 32'h4000}); exp_wr.push_back(32'hB1);
    next_cyc();
    m0_req_valid = 1'b0; m1_req_valid = 1'b0;
    serve_one();
    serve_one();
    // M0 alone, then a tie: round-robin now favours M1
    m0_req_valid = 1'b1; m0_req_addr = 32'h3100; m0_dout = 32'hA2;
    exp_req.push_back({1'b1, 3'd1, 4'hF, 32'h3100}); exp_wr.push_back(32'hA2);
    next_cyc();
    m0_req_valid = 1'b0;
    serve_one();
    m0_req_valid = 1'b1; m0_req_addr = 32'h3200; m0_dout = 32'hA3;
    m1_req_valid = 1'b1; m1_req_addr = 32'h4200; m1_dout = 32'hB4;
`ifdef MEM_ARBITER_RR_EN
    exp_req.push_back({1'b1, 3'd1, 4'hF, 32'h4200}); exp_wr.push_back(32'hB4);
    exp_req.push_back({1'b1, 3'd1, 4'hF, 32'h3200}); exp_wr.push_back(32'hA3);
`else
    exp_req.push_back({1'b1, 3'd1, 4'hF, 32'h3200}); exp_wr.push_back(32'hA3);
    exp_req.push_back({1'b1, 3'd1, 4'hF, 32'h4200}); exp_wr.push_back(32'hB4);
`endif
    next_cyc();
    m0_req_valid = 1'b0; m1_req_valid = 1'b0;
    serve_one();
    serve_one();

    // Overflow on a full slot; first request still served
    s_req_ready = 1'b0;
    next_cyc();
    m0_req_valid = 1'b1; m0_req_addr = 32'h5000; m0_req_len = 3'd1; m0_req_we = 1'b0;
    exp_req.push_back({1'b0, 3'd1, 4'hF, 32'h5000});
    next_cyc();
    m0_req_addr = 32'h6000;
    @(negedge clk); chk("err_before", err_o, 64'h0);
    next_cyc();
    m0_req_valid = 1'b0;
    @(negedge clk);
    chk("err_set", err_o, 64'h1);
    chk("ovf_first_kept", s_req_addr, 64'h5000);
    repeat (3) next_cyc();
    @(negedge clk); chk("err_sticky", err_o, 64'h1);
    next_cyc();
    s_req_ready = 1'b1;
    wait_rdy(0);
    next_cyc();
    s_din_valid = 1'b1; s_din = 32'h55; m0_din_ack = 1'b1;
    exp_rd.push_back(32'h55);
    next_cyc();
    s_din_valid = 1'b0; m0_din_ack = 1'b0;
    seen = 1'b0;
    repeat (4) begin @(negedge clk); seen |= s_req_valid; end
    chk("dropped_not_issued", seen, 64'h0);
    chk("err_still", err_o, 64'h1);

    // Asynchronous reset in the middle of a 4-beat write
    next_cyc();
    m1_req_valid = 1'b1; m1_req_addr = 32'h7000; m1_req_len = 3'd4; m1_req_we = 1'b1;
    m1_req_mask = 4'hF;
    exp_req.push_back({1'b1, 3'd4, 4'hF, 32'h7000});
    exp_wr.push_back(32'h11); exp_wr.push_back(32'h12);
    next_cyc();
    m1_req_valid = 1'b0;
    wait_rdy(1);
    next_cyc(); m1_dout_valid = 1'b1; m1_dout = 32'h11;
    next_cyc(); m1_dout = 32'h12;
    next_cyc(); m1_dout = 32'h13; s_din_valid = 1'b1; m1_din_ack = 1'b1;
    #1;
    chk("pre_rst_routing", {s_dout_valid, m1_din_valid, s_din_ack, m1_req_ready}, 64'hF);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_outputs", {s_dout_valid, m1_din_valid, s_din_ack, m1_req_ready,
                              m0_req_ready, m0_din_valid, s_req_valid, err_o}, 64'h0);
    chk("async_rst_fields", {s_req_we, s_req_len, s_req_mask, s_req_addr}, 64'h0);
    m1_dout_valid = 1'b0; s_din_valid = 1'b0; m1_din_ack = 1'b0;
    repeat (2) next_cyc();
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin @(negedge clk); seen |= s_req_valid | m0_req_ready | m1_req_ready; end
    chk("idle_after_rst", seen, 64'h0);
    next_cyc();
    m0_req_valid = 1'b1; m0_req_addr = 32'h8000; m0_req_len = 3'd1; m0_req_we = 1'b0;
    exp_req.push_back({1'b0, 3'd1, 4'hF, 32'h8000});
    next_cyc();
    m0_req_valid = 1'b0;
    wait_rdy(0);
    next_cyc();
    s_din_valid = 1'b1; s_din = 32'h88; m0_din_ack = 1'b1;
    exp_rd.push_back(32'h88);
    next_cyc();
    s_din_valid = 1'b0; m0_din_ack = 1'b0;
    repeat (3) next_cyc();

    chk("exp_req_drained", exp_req.size(), 64'h0);
    chk("exp_wr_drained", exp_wr.size(), 64'h0);
    chk("exp_rd_drained", exp_rd.size(), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
